// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core.
//   ST_*      : FSM state encodings
//   state_t   : enumerated FSM state type built on those encodings
//   *_MAX     : modulus of each time field
package stopwatch_pkg;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  typedef enum logic [1:0] {
    S_STOP  = ST_STOP,
    S_RUN   = ST_RUN,
    S_CLEAR = ST_CLEAR
  } state_t;

  localparam int MSEC_MAX = 100;
  localparam int SEC_MAX  = 60;
  localparam int MIN_MAX  = 60;
  localparam int HOUR_MAX = 24;

endpackage

// File: rtl/stopwatch_core_if.sv
// Button-pulse inputs and time-field outputs of the stopwatch core.
//   i_btn_run   : run/stop toggle pulse
//   i_btn_clear : clear pulse
//   o_msec/o_sec/o_min/o_hour : binary time fields
//   o_running   : high while counting
// master = button/display side, slave = stopwatch core.
interface stopwatch_core_if;
  logic       i_btn_run;
  logic       i_btn_clear;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_running;

  modport master (
    output i_btn_run, i_btn_clear,
    input  o_msec, o_sec, o_min, o_hour, o_running
  );

  modport slave (
    input  i_btn_run, i_btn_clear,
    output o_msec, o_sec, o_min, o_hour, o_running
  );
endinterface

// File: rtl/stopwatch_tick_gen.sv
// Centisecond prescaler.
//   clk, reset : clock, async active-high reset
//   en         : count enable (stopwatch running)
//   clr        : synchronous clear to phase 0
//   o_tick     : combinational, high on the last count while enabled
// While disabled the count holds, so the tick phase survives pause/resume.
module stopwatch_tick_gen #(
  parameter int F_COUNT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic o_tick
);

  localparam int W = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(F_COUNT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign o_tick = en && (cnt == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: run/stop/clear FSM plus cascaded centisecond..hour counters.
//   clk, reset : clock, async active-high reset
//   bus        : button pulses in, registered time fields and running flag out
// CLEAR is a one-cycle state; fields are zeroed on the edge that leaves it.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int F_COUNT = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_core_if.slave  bus
);

  state_t state;
  logic   tick;
  logic   run_en;
  logic   clr_en;

  assign run_en = (state == S_RUN);
  assign clr_en = (state == S_CLEAR);

  stopwatch_tick_gen #(.F_COUNT(F_COUNT)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (run_en),
    .clr    (clr_en),
    .o_tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_STOP;
      bus.o_running <= 1'b0;
      bus.o_msec    <= '0;
      bus.o_sec     <= '0;
      bus.o_min     <= '0;
      bus.o_hour    <= '0;
    end else begin
      // o_running tracks the next state so it is registered alongside it.
      case (state)
        S_STOP: begin
          if (bus.i_btn_clear) begin
            state         <= S_CLEAR;
            bus.o_running <= 1'b0;
          end else if (bus.i_btn_run) begin
            state         <= S_RUN;
            bus.o_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.i_btn_run) begin
            state         <= S_STOP;
            bus.o_running <= 1'b0;
          end
        end
        default: begin
          state         <= S_STOP;
          bus.o_running <= 1'b0;
        end
      endcase

      // Tick only exists in RUN, so it never collides with the clear.
      if (state == S_CLEAR) begin
        bus.o_msec <= '0;
        bus.o_sec  <= '0;
        bus.o_min  <= '0;
        bus.o_hour <= '0;
      end else if (tick) begin
        if (bus.o_msec == 7'(MSEC_MAX - 1)) begin
          bus.o_msec <= '0;
          if (bus.o_sec == 6'(SEC_MAX - 1)) begin
            bus.o_sec <= '0;
            if (bus.o_min == 6'(MIN_MAX - 1)) begin
              bus.o_min <= '0;
              if (bus.o_hour == 5'(HOUR_MAX - 1)) bus.o_hour <= '0;
              else                                 bus.o_hour <= bus.o_hour + 5'd1;
            end else begin
              bus.o_min <= bus.o_min + 6'd1;
            end
          end else begin
            bus.o_sec <= bus.o_sec + 6'd1;
          end
        end else begin
          bus.o_msec <= bus.o_msec + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core (F_COUNT = 4).
// Reference model: the displayed time is the number of clock edges spent in
// RUN since the last clear, divided by F_COUNT, split into h:m:s.cs.
module tb_stopwatch_core;

  localparam int F = 4;

  logic clk;
  logic reset;

  stopwatch_core_if bus ();

  stopwatch_core #(.F_COUNT(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 = stopped, 1 = running, 2 = clearing
  int    m_mode;
  longint m_run_cycles;

  logic [24:0] obs;
  assign obs = {bus.o_msec, bus.o_sec, bus.o_min, bus.o_hour, bus.o_running};

  function automatic logic [24:0] model_vec();
    longint cs;
    logic [6:0] ms;
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    cs = m_run_cycles / F;
    ms = 7'(cs % 100);
    s  = 6'((cs / 100) % 60);
    m  = 6'((cs / 6000) % 60);
    h  = 5'((cs / 360000) % 24);
    return {ms, s, m, h, (m_mode == 1)};
  endfunction

  task automatic model_reset();
    m_mode       = 0;
    m_run_cycles = 0;
  endtask

  task automatic model_edge(input bit run, input bit clr);
    case (m_mode)
      0: if (clr) m_mode = 2; else if (run) m_mode = 1;
      1: begin
        m_run_cycles++;
        if (run) m_mode = 0;
      end
      default: begin
        m_run_cycles = 0;
        m_mode       = 0;
      end
    endcase
  endtask

  // Entered and left at a falling edge.
  task automatic step(input bit run, input bit clr);
    bus.i_btn_run   = run;
    bus.i_btn_clear = clr;
    @(posedge clk);
    model_edge(run, clr);
    @(negedge clk);
    bus.i_btn_run   = 1'b0;
    bus.i_btn_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (obs !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h required %h", obs, 25'd0);
    end
    idle(5);
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++;
      $display("FAIL reset_idle: got %h required %h", obs, model_vec());
    end
  endtask

  task automatic test_first_second();
    step(1'b1, 1'b0);
    n_cmp++;
    if (bus.o_running !== 1'b1) begin
      n_bad++;
      $display("FAIL running_rise: got %b required 1", bus.o_running);
    end
    idle(F * 100 - 1);
    n_cmp++;
    if (bus.o_sec !== 6'd0 || bus.o_msec !== 7'd99) begin
      n_bad++;
      $display("FAIL before_first_sec: got %0d.%0d required 0.99", bus.o_sec, bus.o_msec);
    end
    idle(1);
    n_cmp++;
    if ({bus.o_sec, bus.o_msec, bus.o_running} !== {6'd1, 7'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL first_sec: got %0d.%0d run=%b required 1.0 run=1",
               bus.o_sec, bus.o_msec, bus.o_running);
    end
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++;
      $display("FAIL first_sec_model: got %h required %h", obs, model_vec());
    end
  endtask

  task automatic test_pause_resume();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(10 * F);
    step(1'b1, 1'b0);
    idle(50);
    n_cmp++;
    if ({bus.o_msec, bus.o_running} !== {7'd10, 1'b0}) begin
      n_bad++;
      $display("FAIL pause_hold: got msec=%0d run=%b required msec=10 run=0",
               bus.o_msec, bus.o_running);
    end
    step(1'b1, 1'b0);
    idle(F - 2);
    n_cmp++;
    if (bus.o_msec !== 7'd10) begin
      n_bad++;
      $display("FAIL resume_early: got %0d required 10", bus.o_msec);
    end
    idle(1);
    n_cmp++;
    if (bus.o_msec !== 7'd11) begin
      n_bad++;
      $display("FAIL resume_phase: got %0d required 11", bus.o_msec);
    end
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++;
      $display("FAIL resume_model: got %h required %h", obs, model_vec());
    end
  endtask

  task automatic test_clear();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(37 * F);
    step(1'b1, 1'b0);
    n_cmp++;
    if (bus.o_msec !== 7'd37) begin
      n_bad++;
      $display("FAIL clear_setup: got %0d required 37", bus.o_msec);
    end
    step(1'b0, 1'b1);
    n_cmp++;
    if (bus.o_msec !== 7'd37) begin
      n_bad++;
      $display("FAIL clear_first_edge: got %0d required 37", bus.o_msec);
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs !== 25'd0) begin
      n_bad++;
      $display("FAIL clear_zero: got %h required %h", obs, 25'd0);
    end
    step(1'b1, 1'b0);
    idle(3 * F + 1);
    step(1'b0, 1'b1);
    idle(2 * F);
    n_cmp++;
    if (obs !== model_vec() || bus.o_msec !== 7'd5) begin
      n_bad++;
      $display("FAIL clear_in_run: got %h required %h", obs, model_vec());
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0);
    n_cmp++;
    if (bus.o_running !== 1'b0) begin
      n_bad++;
      $display("FAIL sim_setup: got run=%b required 0", bus.o_running);
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (bus.o_running !== 1'b0 || bus.o_msec !== 7'd5) begin
      n_bad++;
      $display("FAIL sim_stop_clear_wins: got run=%b msec=%0d required run=0 msec=5",
               bus.o_running, bus.o_msec);
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (obs !== 25'd0) begin
      n_bad++;
      $display("FAIL sim_stop_zero: got %h required %h", obs, 25'd0);
    end
    step(1'b1, 1'b0);
    idle(6 * F);
    step(1'b1, 1'b1);
    idle(10);
    n_cmp++;
    if ({bus.o_msec, bus.o_running} !== {7'd6, 1'b0} || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL sim_run_stop: got %h required %h", obs, model_vec());
    end
  endtask

  task automatic test_run_on_tick();
    step(1'b1, 1'b0);
    while (((m_run_cycles + 1) % F) != 0) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_cmp++;
    if (obs !== model_vec() || bus.o_running !== 1'b0) begin
      n_bad++;
      $display("FAIL run_on_tick: got %h required %h", obs, model_vec());
    end
    step(1'b1, 1'b0);
    idle(F - 1);
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++;
      $display("FAIL wrap_phase_early: got %h required %h", obs, model_vec());
    end
    idle(1);
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++;
      $display("FAIL wrap_phase_tick: got %h required %h", obs, model_vec());
    end
  endtask

  task automatic test_carry();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(5999 * F);
    n_cmp++;
    if ({bus.o_min, bus.o_sec, bus.o_msec} !== {6'd0, 6'd59, 7'd99}) begin
      n_bad++;
      $display("FAIL carry_pre: got %0d:%0d.%0d required 0:59.99",
               bus.o_min, bus.o_sec, bus.o_msec);
    end
    idle(F);
    n_cmp++;
    if ({bus.o_min, bus.o_sec, bus.o_msec} !== {6'd1, 6'd0, 7'd0}) begin
      n_bad++;
      $display("FAIL carry_min: got %0d:%0d.%0d required 1:0.0",
               bus.o_min, bus.o_sec, bus.o_msec);
    end
    n_cmp++;
    if (obs !== model_vec()) begin
      n_bad++;
      $display("FAIL carry_model: got %h required %h", obs, model_vec());
    end
  endtask

  task automatic test_random();
    int r;
    bit run, clr;
    int hold;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 99));
      run = (r < 4) || (r == 6);
      clr = (r == 4) || (r == 5) || (r == 6);
      if (r == 7) hold = int'($urandom_range(2, 4));
      if (hold > 0) begin
        run = 1'b1;
        hold--;
      end
      step(run, clr);
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h required %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    if (m_mode != 1) step(1'b1, 1'b0);
    idle(3 * F + 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 25'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %h required %h", obs, 25'd0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(20);
    n_cmp++;
    if (obs !== 25'd0 || obs !== model_vec()) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %h required %h", obs, model_vec());
    end
    step(1'b1, 1'b0);
    idle(F);
    n_cmp++;
    if (obs !== model_vec() || bus.o_msec !== 7'd1) begin
      n_bad++;
      $display("FAIL post_reset_run: got %h required %h", obs, model_vec());
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.i_btn_run   = 1'b0;
    bus.i_btn_clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_first_second();
    test_pause_resume();
    test_clear();
    test_simultaneous();
    test_run_on_tick();
    test_carry();
    test_random();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
